uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter: OVERSAMPLE, 16, baud_tick pulses per bit period; even, >= 8.
REQ-002 Port: clk  input  1  system clock; all flops on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: baud_tick  input  1  single-clk enable at OVERSAMPLE x baud rate.
REQ-005 Port: rxd  input  1  asynchronous serial line; idle high.
REQ-006 Port: rx_ready  input  1  consumer accepts data_rd this clk.
REQ-007 Port: err_clr  input  1  clears sticky error flags.
REQ-008 Port: data_rd  output  8  last received byte.
REQ-009 Port: rx_valid  output  1  data_rd holds an unconsumed byte.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: frame_err  output  1  sticky; stop bit sampled low.
REQ-012 Port: overrun  output  1  sticky; byte completed while rx_valid held.

Function
REQ-013 rxd SHALL pass a 2-flop synchronizer (reset value 1) before any use; all frame logic uses the synchronized value only.
REQ-014 Frame format SHALL be 1 start (0), 8 data LSB-first, 1 stop (1); no parity.
REQ-015 Tick counter width SHALL be $clog2(OVERSAMPLE); bit counter 3 bits; state, counters and shift register advance only on clk edges with baud_tick=1.
REQ-016 States SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: an arm flag SHALL set on any tick with rxd=1; on a tick with rxd=0 and arm=1 -> START, tick count 0, arm cleared.
REQ-018 START: at tick count OVERSAMPLE/2-1, rxd=0 -> DATA with tick count 0; rxd=1 -> IDLE, glitch discarded, no flag set.
REQ-019 DATA: at tick count OVERSAMPLE-1 sample rxd into shift register MSB while shifting right; after the 8th sample -> STOP with tick count 0.
REQ-020 STOP: at tick count OVERSAMPLE-1, rxd=1 -> load data_rd from shift register and set rx_valid on next clk edge; rxd=0 -> set frame_err, no load; both -> IDLE.
REQ-021 Load while rx_valid=1 and rx_ready=0 SHALL set overrun and SHALL NOT change data_rd.
REQ-022 rx_valid SHALL clear on the clk after rx_valid=1 and rx_ready=1, independent of baud_tick.
REQ-023 Load and consume in the same clk SHALL load new data, keep rx_valid=1, not set overrun.
REQ-024 err_clr SHALL clear frame_err and overrun next clk; a set in the same clk wins over err_clr.
REQ-025 After a framing error a low-held line (break) SHALL NOT start a new frame until rxd=1 is seen at a tick.
REQ-026 rx_ready while rx_valid=0 SHALL have no effect.

Reset
REQ-027 reset_n low SHALL immediately force: state IDLE, counters 0, arm 0, synchronizer 1, shift register 0, data_rd 8'h00, rx_valid 0, busy 0, frame_err 0, overrun 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no flag or data; reception resumes normally after release.

Verification (OVERSAMPLE=16, baud_tick=1 every clk unless noted)
REQ-029 Frame 0xA5 (bits 1,0,1,0,0,1,0,1), rx_ready=0 -> data_rd=8'hA5, rx_valid=1 within 2 clk + sync delay after stop-bit mid-sample, no errors; rx_ready=1 one clk -> rx_valid=0 next clk.
REQ-030 rxd low 4 ticks then high -> busy pulses, returns to IDLE at tick 7, rx_valid=0, frame_err=0.
REQ-031 Frame 0x3C with stop bit 0, then rxd held low 40 ticks -> frame_err=1, rx_valid=0, no second start; rxd high then frame 0x5A -> data_rd=8'h5A; err_clr -> frame_err=0.
REQ-032 Frames 0x11 then 0x22, rx_ready=0 -> data_rd=8'h11, overrun=1; rx_ready=1 -> rx_valid=0; err_clr asserted same clk as next overrun -> overrun stays 1.
REQ-033 reset_n low during DATA bit 3 -> all outputs at reset values asynchronously; after release frame 0xC3 -> data_rd=8'hC3, no errors.
REQ-034 baud_tick every 4th clk, frame 0x96 with rx_ready held 1 -> rx_valid high exactly one clk, data_rd=8'h96.

Source files
------------

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : 8N1 UART receiver driven by an oversampling baud tick. The serial
//            line is double-flop synchronized, the start bit is qualified at
//            its mid-point, data bits are sampled once per bit period, and the
//            stop bit decides between loading the byte and flagging a framing
//            error.
// Ports    : clk        - system clock, rising edge
//            reset_n    - asynchronous active-low reset
//            baud_tick  - single-clk enable at OVERSAMPLE x baud rate
//            rxd        - asynchronous serial input, idle high
//            rx_ready   - consumer accepts data_rd this clk
//            err_clr    - clears sticky frame_err / overrun
//            data_rd    - last received byte
//            rx_valid   - data_rd holds an unconsumed byte
//            busy       - receiver is inside a frame (not IDLE)
//            frame_err  - sticky, stop bit sampled low
//            overrun    - sticky, byte completed while rx_valid still held
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] data_rd,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int c_TICK_W = $clog2(OVERSAMPLE);

    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_state;
    logic [c_TICK_W-1:0] r_tick;
    logic [2:0]          r_bit_cnt;
    logic                r_arm;
    logic [7:0]          r_shift;

    logic w_rxd_s;
    logic w_stop_sample;
    logic w_load;
    logic w_ferr_set;
    logic w_ovr_set;
    logic w_consume;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle line level so that a reset
    // release never looks like a start edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s = r_sync2;

    // ------------------------------------------------------------------------
    // Frame FSM. Everything here advances only on baud ticks.
    // The arm flag demands a high line at a tick before a low line can start a
    // frame; this keeps a held-low break after a bad stop bit from re-triggering.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= 3'd0;
            r_arm     <= 1'b0;
            r_shift   <= 8'h00;
            busy      <= 1'b0;
        end else if (baud_tick) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_rxd_s) begin
                        r_arm <= 1'b1;
                    end else if (r_arm) begin
                        r_state <= c_S_START;
                        r_tick  <= '0;
                        r_arm   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                c_S_START: begin
                    // Half a bit in: still low means a real start bit, and the
                    // tick counter is now centred for the data bits.
                    if (r_tick == c_TICK_HALF) begin
                        r_tick <= '0;
                        if (!w_rxd_s) begin
                            r_state   <= c_S_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_state <= c_S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_tick <= r_tick + c_TICK_ONE;
                    end
                end

                c_S_DATA: begin
                    if (r_tick == c_TICK_LAST) begin
                        r_tick    <= '0;
                        // LSB-first: new bit enters at the MSB and walks down.
                        r_shift   <= {w_rxd_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_S_STOP;
                        end
                    end else begin
                        r_tick <= r_tick + c_TICK_ONE;
                    end
                end

                c_S_STOP: begin
                    if (r_tick == c_TICK_LAST) begin
                        r_tick  <= '0;
                        r_state <= c_S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_tick <= r_tick + c_TICK_ONE;
                    end
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_tick  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Stop-bit decision point and the events derived from it.
    assign w_stop_sample = baud_tick && (r_state == c_S_STOP) && (r_tick == c_TICK_LAST);
    assign w_load        = w_stop_sample && w_rxd_s;
    assign w_ferr_set    = w_stop_sample && !w_rxd_s;
    assign w_consume     = rx_valid && rx_ready;
    // A byte only overruns if the held one is not being taken in the same clk.
    assign w_ovr_set     = w_load && rx_valid && !rx_ready;

    // ------------------------------------------------------------------------
    // Output holding register and sticky flags. Consumption is evaluated every
    // clk, independent of baud_tick.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_rd  <= 8'h00;
            rx_valid <= 1'b0;
        end else if (w_load && !w_ovr_set) begin
            data_rd  <= r_shift;
            rx_valid <= 1'b1;
        end else if (w_consume) begin
            rx_valid <= 1'b0;
        end
    end

    // Setting a flag takes priority over clearing it in the same clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_ferr_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end

            if (w_ovr_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Self-checking bench for uart_rx_core. Frames are driven as whole
//            bit periods counted in baud ticks; expected outputs come from a
//            frame-level model (pending byte, valid, sticky flags) updated by
//            the rules of the receiver, plus directed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int OS = 16;

    logic       clk;
    logic       reset_n;
    logic       baud_tick;
    logic       rxd;
    logic       rx_ready;
    logic       err_clr;
    logic [7:0] data_rd;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int div   = 1;
    int tick_cnt;

    // frame-level reference model
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ferr;
    logic       m_ovr;

    logic mon_en = 1'b0;
    int   mon_cnt;

    uart_rx_core #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .data_rd   (data_rd),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // baud tick: one clk high every 'div' clks, changed 1 time unit after the edge
    initial begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (tick_cnt == 0);
            tick_cnt  = (tick_cnt + 1) % div;
        end
    end

    // counts clks with rx_valid high while enabled
    always @(negedge clk) begin
        if (!mon_en) mon_cnt <= 0;
        else if (rx_valid) mon_cnt <= mon_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ":data"},  {24'd0, data_rd}, {24'd0, m_data});
        check({tag, ":valid"}, {31'd0, rx_valid}, {31'd0, m_valid});
        check({tag, ":ferr"},  {31'd0, frame_err}, {31'd0, m_ferr});
        check({tag, ":ovr"},   {31'd0, overrun}, {31'd0, m_ovr});
        check({tag, ":busy"},  {31'd0, busy}, 32'd0);
    endtask

    // returns at the n-th clk edge on which the DUT sees baud_tick=1
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        wait_ticks(n * OS);
        #2;
    endtask

    task automatic pulse_ready();
        @(posedge clk); #2;
        rx_ready = 1'b1;
        @(posedge clk); #2;
        rx_ready = 1'b0;
        if (m_valid) m_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2;
        err_clr = 1'b1;
        @(posedge clk); #2;
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Drives one 8N1 frame. rdy/clr at load pulse rx_ready/err_clr on the clk of
    // the stop-bit decision: 11th tick of the stop bit (2 sync clks + half bit),
    // only meaningful with a tick every clk.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic rdy_at_load, input logic clr_at_load);
        logic set_ovr;
        rxd = 1'b0;
        wait_ticks(OS); #2;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_ticks(OS); #2;
        end
        rxd = stop;
        if (rdy_at_load || clr_at_load) begin
            wait_ticks(10); #2;
            rx_ready = rdy_at_load;
            err_clr  = clr_at_load;
            wait_ticks(1); #2;
            rx_ready = 1'b0;
            err_clr  = 1'b0;
            wait_ticks(OS - 11); #2;
        end else begin
            wait_ticks(OS); #2;
        end
        set_ovr = 1'b0;
        if (stop) begin
            if (m_valid && !rdy_at_load) begin
                m_ovr   = 1'b1;
                set_ovr = 1'b1;
            end else begin
                m_data  = b;
                m_valid = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
            if (rdy_at_load) m_valid = 1'b0;
        end
        if (clr_at_load) begin
            m_ferr = !stop;
            m_ovr  = set_ovr;
        end
    endtask

    initial begin
        int         hits;
        logic [7:0] b;
        logic       stop;

        reset_n  = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        check_model("reset");
        reset_n = 1'b1;
        idle_bits(2);

        // basic frame, then consume
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        check_model("a5");
        check("a5_const", {24'd0, data_rd}, 32'h0000_00A5);
        pulse_ready();
        check("a5_consume", {31'd0, rx_valid}, 32'd0);

        // start glitch: low for 4 ticks, decision at the 8th START tick
        rxd = 1'b0;
        wait_ticks(4); #2;
        rxd = 1'b1;
        wait_ticks(6); #1;
        check("glitch_busy", {31'd0, busy}, 32'd1);
        wait_ticks(1); #1;
        check("glitch_idle", {31'd0, busy}, 32'd0);
        idle_bits(1);
        check_model("glitch");

        // framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            wait_ticks(1); #1;
            if (busy) hits++;
        end
        check("break_busy", hits, 32'd0);
        check("break_ferr", {31'd0, frame_err}, 32'd1);
        idle_bits(2);
        check_model("break");
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        check_model("after_break");
        check("5a_const", {24'd0, data_rd}, 32'h0000_005A);
        pulse_clr();
        check("ferr_clr", {31'd0, frame_err}, 32'd0);
        pulse_ready();

        // overrun
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        check_model("ovr");
        check("ovr_const", {24'd0, data_rd, overrun}, 32'h0000_0023);
        pulse_ready();
        check("ovr_consume", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        idle_bits(1);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1);
        idle_bits(2);
        check_model("ovr_set_wins");

        // load and consume in the same clk
        pulse_clr();
        send_frame(8'h55, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        check_model("load_consume");

        // reset during data bit 3
        b = 8'h6E;
        rxd = 1'b0;
        wait_ticks(OS); #2;
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            wait_ticks(OS); #2;
        end
        rxd = b[3];
        wait_ticks(OS / 2); #2;
        check("mid_busy", {31'd0, busy}, 32'd1);
        #1;
        reset_n = 1'b0;
        rxd = 1'b1;
        #1;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        check_model("async_rst");
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        idle_bits(2);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        check_model("c3");

        // slow ticks, consumer always ready
        div = 4;
        idle_bits(1);
        rx_ready = 1'b1;
        m_valid  = 1'b0;
        @(posedge clk); #2;
        mon_en = 1'b1;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        @(negedge clk); #1;
        check("valid_one_clk", mon_cnt, 32'd1);
        mon_en   = 1'b0;
        rx_ready = 1'b0;
        m_valid  = 1'b0;
        check_model("96");

        // randomized frames against the model
        for (int n = 0; n < 12; n++) begin
            div = int'($urandom_range(1, 4));
            idle_bits(1);
            if ($urandom_range(0, 1) == 1) pulse_ready();
            if ($urandom_range(0, 3) == 0) pulse_clr();
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, 1'b0, 1'b0);
            idle_bits(2);
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
